// File: rtl/pc_gen.sv
// Fetch program-counter generator: boot/run/halt sequencing, prioritised redirects and misalignment trap.
// Define PC_C_EXT_EN to enable 16-bit instruction increments and 2-byte target alignment.
module pc_gen #(
  parameter int          XLEN       = 64,
  parameter logic [63:0] RESET_PC   = 64'h80000000,
  parameter int          INST_BYTES = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            halt_req,
  input  logic            trap_valid,
  input  logic [XLEN-1:0] trap_pc,
  input  logic            jalr_valid,
  input  logic [XLEN-1:0] jalr_pc,
  input  logic            br_valid,
  input  logic [XLEN-1:0] br_pc,
  input  logic            is_c,
  input  logic            pc_ready,
  output logic            pc_valid,
  output logic [XLEN-1:0] pc,
  output logic            flush,
  output logic            misalign_err,
  output logic [XLEN-1:0] misalign_addr,
  output logic [1:0]      state
);

  localparam logic [XLEN-1:0] RST_PC = RESET_PC[XLEN-1:0];

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d, addr_q, addr_d;
  logic            flush_q, flush_d, err_q, err_d;
  logic [XLEN-1:0] target, incr;
  logic            redirect, misaligned;

  // Redirect target selection by priority; jalr always drops bit 0.
  always_comb begin
    redirect = trap_valid | jalr_valid | br_valid;
    if (trap_valid)
      target = trap_pc;
    else if (jalr_valid)
      target = {jalr_pc[XLEN-1:1], 1'b0};
    else
      target = br_pc;
  end

`ifdef PC_C_EXT_EN
  assign misaligned = target[0];
  assign incr       = is_c ? XLEN'(2) : XLEN'(INST_BYTES);
`else
  logic unused_is_c;
  assign unused_is_c = is_c;
  assign misaligned  = |target[1:0];
  assign incr        = XLEN'(INST_BYTES);
`endif

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    addr_d  = addr_q;
    flush_d = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      BOOT: state_d = RUN;
      RUN: begin
        // Halt wins over any redirect; a bad target also parks the core.
        if (halt_req) begin
          state_d = HALT;
        end else if (redirect) begin
          if (misaligned) begin
            err_d   = 1'b1;
            addr_d  = target;
            state_d = HALT;
          end else begin
            pc_d    = target;
            flush_d = 1'b1;
          end
        end else if (pc_ready) begin
          pc_d = pc_q + incr;
        end
      end
      default: state_d = HALT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= BOOT;
      pc_q    <= RST_PC;
      addr_q  <= '0;
      flush_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      addr_q  <= addr_d;
      flush_q <= flush_d;
      err_q   <= err_d;
    end
  end

  assign pc_valid      = (state_q == RUN);
  assign pc            = pc_q;
  assign flush         = flush_q;
  assign misalign_err  = err_q;
  assign misalign_addr = addr_q;
  assign state         = state_q;

endmodule

// File: tb/tb_pc_gen.sv
// Scoreboard bench for pc_gen: stimulus pushes model expectations, a monitor pops and compares each cycle.
module tb_pc_gen;

  localparam logic [63:0] RST_PC = 64'h80000000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        halt_req = 1'b0;
  logic        trap_valid = 1'b0;
  logic [63:0] trap_pc = '0;
  logic        jalr_valid = 1'b0;
  logic [63:0] jalr_pc = '0;
  logic        br_valid = 1'b0;
  logic [63:0] br_pc = '0;
  logic        is_c = 1'b0;
  logic        pc_ready = 1'b0;
  logic        pc_valid;
  logic [63:0] pc;
  logic        flush;
  logic        misalign_err;
  logic [63:0] misalign_addr;
  logic [1:0]  state;

  pc_gen dut (
    .clk(clk), .rst_n(rst_n), .halt_req(halt_req),
    .trap_valid(trap_valid), .trap_pc(trap_pc),
    .jalr_valid(jalr_valid), .jalr_pc(jalr_pc),
    .br_valid(br_valid), .br_pc(br_pc),
    .is_c(is_c), .pc_ready(pc_ready),
    .pc_valid(pc_valid), .pc(pc), .flush(flush),
    .misalign_err(misalign_err), .misalign_addr(misalign_addr), .state(state)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        valid;
    logic [63:0] pc;
    logic        flush;
    logic        err;
    logic [63:0] addr;
    logic [1:0]  state;
  } exp_t;

  exp_t sb[$];
  int   vectors = 0;
  int   miscompares = 0;

  // Reference model: 0 = booting, 1 = running, 2 = halted.
  int          m_state;
  logic [63:0] m_pc, m_addr;
  logic        m_flush, m_err;

  function automatic exp_t snapshot();
    exp_t e;
    e.valid = (m_state == 1);
    e.pc    = m_pc;
    e.flush = m_flush;
    e.err   = m_err;
    e.addr  = m_addr;
    e.state = 2'(m_state);
    return e;
  endfunction

  task automatic modelReset();
    m_state = 0;
    m_pc    = RST_PC;
    m_flush = 0;
    m_err   = 0;
    m_addr  = '0;
  endtask

  task automatic modelStep(input logic r, input logic h, input logic tv, input logic [63:0] tp,
                           input logic jv, input logic [63:0] jp, input logic bv, input logic [63:0] bp,
                           input logic ic, input logic rdy);
    logic [63:0] tgt;
    int unsigned align, step;
`ifdef PC_C_EXT_EN
    align = 2;
    step  = ic ? 2 : 4;
`else
    align = 4;
    step  = 4;
`endif
    if (!r) begin
      modelReset();
      return;
    end
    m_flush = 0;
    m_err   = 0;
    if (m_state == 0) begin
      m_state = 1;
    end else if (m_state == 1) begin
      if (h) begin
        m_state = 2;
      end else if (tv || jv || bv) begin
        if (tv)      tgt = tp;
        else if (jv) tgt = jp - (jp % 2);
        else         tgt = bp;
        if (tgt % 64'(align) != 0) begin
          m_err   = 1;
          m_addr  = tgt;
          m_state = 2;
        end else begin
          m_pc    = tgt;
          m_flush = 1;
        end
      end else if (rdy) begin
        m_pc = m_pc + 64'(step);
      end
    end
  endtask

  task automatic checkOutput(input exp_t e, input string name);
    vectors++;
    if (pc_valid !== e.valid || pc !== e.pc || flush !== e.flush ||
        misalign_err !== e.err || misalign_addr !== e.addr || state !== e.state) begin
      miscompares++;
      $display("[TB] FAIL %s: got valid=%0b pc=%h flush=%0b err=%0b addr=%h state=%0d, expected valid=%0b pc=%h flush=%0b err=%0b addr=%h state=%0d",
               name, pc_valid, pc, flush, misalign_err, misalign_addr, state,
               e.valid, e.pc, e.flush, e.err, e.addr, e.state);
    end
  endtask

  task automatic applyStimulus(input logic r, input logic h, input logic tv, input logic [63:0] tp,
                               input logic jv, input logic [63:0] jp, input logic bv, input logic [63:0] bp,
                               input logic ic, input logic rdy);
    @(negedge clk);
    rst_n      = r;
    halt_req   = h;
    trap_valid = tv;
    trap_pc    = tp;
    jalr_valid = jv;
    jalr_pc    = jp;
    br_valid   = bv;
    br_pc      = bp;
    is_c       = ic;
    pc_ready   = rdy;
    modelStep(r, h, tv, tp, jv, jp, bv, bp, ic, rdy);
    sb.push_back(snapshot());
  endtask

  task automatic idle(input logic rdy, input logic ic);
    applyStimulus(1, 0, 0, '0, 0, '0, 0, '0, ic, rdy);
  endtask

  task automatic doReset();
    applyStimulus(0, 0, 0, '0, 0, '0, 0, '0, 0, 0);
    applyStimulus(0, 0, 0, '0, 0, '0, 0, '0, 0, 0);
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) checkOutput(sb.pop_front(), $sformatf("cycle@%0t", $time));
    end
  end

  initial begin
    logic [63:0] tgt;
    logic r, h, tv, jv, bv;
    logic [63:0] tp, jp, bp;

    modelReset();
    doReset();
    idle(1, 0);
    idle(1, 0);
    idle(1, 0);
    repeat (3) idle(0, 0);
    applyStimulus(1, 0, 0, '0, 1, 64'h80001003, 0, '0, 0, 0);
    idle(0, 0);

    doReset();
    idle(1, 0);
    applyStimulus(1, 0, 1, 64'h80000100, 1, 64'h80000300, 1, 64'h80000400, 0, 1);
    idle(1, 0);
    applyStimulus(1, 1, 0, '0, 0, '0, 1, 64'h80000200, 0, 1);
    applyStimulus(1, 0, 0, '0, 0, '0, 1, 64'h80000300, 0, 1);
    applyStimulus(1, 0, 1, 64'h80000400, 0, '0, 0, '0, 0, 1);

    doReset();
    idle(1, 0);
    applyStimulus(1, 0, 0, '0, 0, '0, 1, 64'hFFFFFFFFFFFFFFFC, 0, 1);
    idle(1, 0);
    idle(1, 0);

    doReset();
    idle(1, 1);
    idle(1, 1);
    idle(1, 0);

    // Redirect so flush is high, then pull reset between clock edges.
    applyStimulus(1, 0, 0, '0, 0, '0, 1, 64'h80000040, 0, 1);
    @(posedge clk);
    #3;
    rst_n = 0;
    modelReset();
    #1;
    checkOutput(snapshot(), "async reset");
    doReset();

    for (int i = 0; i < 2000; i++) begin
      r  = !((m_state == 2 && $urandom_range(0, 3) == 0) || $urandom_range(0, 199) == 0);
      h  = ($urandom_range(0, 63) == 0);
      tv = ($urandom_range(0, 15) == 0);
      jv = ($urandom_range(0, 9) == 0);
      bv = ($urandom_range(0, 7) == 0);
      tp = RST_PC + 64'($urandom_range(0, 255) * 4);
      jp = RST_PC + 64'($urandom_range(0, 255) * 4) + 64'($urandom_range(0, 1));
      bp = RST_PC + 64'($urandom_range(0, 255) * 4);
      if ($urandom_range(0, 7) == 0) tp = tp + 64'($urandom_range(1, 3));
      if ($urandom_range(0, 7) == 0) jp = jp + 64'($urandom_range(1, 3));
      if ($urandom_range(0, 7) == 0) bp = bp + 64'($urandom_range(1, 3));
      applyStimulus(r, h, tv, tp, jv, jp, bv, bp, 1'($urandom_range(0, 1)),
                    ($urandom_range(0, 3) != 0));
    end

    idle(1, 0);
    repeat (3) @(posedge clk);
    #2;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
